sha512_padder: RTL and testbench

Message front end for the SHA-512 core. Accepts an arbitrary-length byte message as a stream of 64-bit big-endian words and packs it into 1024-bit chunks. Applies FIPS 180-4 padding: a 0x80 byte, zero fill, and a 128-bit bit-length field. Hands each chunk to the downstream chunk-compression engine over a valid/ready handshake and flags the final chunk of each message.

---
 rtl/sha512_padder.sv | 147 ++++++++++++++
 tb/tb_sha512_padder.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha512_padder.sv
`default_nettype none
// ============================================================================
//  Module   : sha512_padder
//  Purpose  : Packs a 64-bit word message stream into 1024-bit SHA-512 chunks
//             and applies the 0x80 / zero-fill / 128-bit length padding.
//  Revision : 1.0  initial release
// ============================================================================
module sha512_padder #(
    parameter int LEN_W = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [63:0]   in_data,
    input  logic          in_last,
    input  logic [3:0]    in_bytes,
    output logic          chunk_valid,
    input  logic          chunk_ready,
    output logic [1023:0] chunk,
    output logic          chunk_last
);

    localparam logic [63:0] c_PAD_WORD = 64'h8000_0000_0000_0000;

    typedef enum logic [0:0] {
        S_FILL = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [15:0][63:0]   r_buf;
    logic [3:0]          r_widx;
    logic [LEN_W-1:0]    r_len;
    logic                r_extra;
    logic                r_last;
    logic                r_p16;

    logic                w_accept;
    logic                w_hs;
    logic [3:0]          w_n;
    logic [4:0]          w_p;
    logic [63:0]         w_last_word;
    logic [LEN_W-1:0]    w_len_last;
    logic [127:0]        w_field_last;
    logic [127:0]        w_field_cur;

    assign in_ready    = (r_state == S_FILL);
    assign chunk_valid = (r_state == S_EMIT);
    assign chunk       = r_buf;
    assign chunk_last  = r_last;

    assign w_accept     = in_valid && in_ready;
    assign w_hs         = chunk_valid && chunk_ready;
    assign w_n          = (in_bytes > 4'd8) ? 4'd8 : in_bytes;
    // A full last word pushes the pad byte into the following word slot
    assign w_p          = {1'b0, r_widx} + {4'd0, (w_n == 4'd8)};
    assign w_len_last   = r_len + LEN_W'({w_n, 3'b000});
    assign w_field_last = 128'(w_len_last);
    assign w_field_cur  = 128'(r_len);

    always_comb begin
        w_last_word = '0;
        for (int k = 0; k < 8; k++) begin
            if (4'(k) < w_n) begin
                w_last_word[63-8*k -: 8] = in_data[63-8*k -: 8];
            end else if (4'(k) == w_n) begin
                w_last_word[63-8*k -: 8] = 8'h80;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_FILL: if (w_accept && (in_last || r_widx == 4'd15)) w_state_next = S_EMIT;
            S_EMIT: if (w_hs && !r_extra) w_state_next = S_FILL;
            default: w_state_next = S_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_buf   <= '0;
            r_widx  <= 4'd0;
            r_len   <= '0;
            r_extra <= 1'b0;
            r_last  <= 1'b0;
            r_p16   <= 1'b0;
        end else if (w_accept) begin
            if (!in_last) begin
                r_buf[4'd15 - r_widx] <= in_data;
                r_len                 <= r_len + LEN_W'(64);
                r_widx                <= r_widx + 4'd1;
                r_last                <= 1'b0;
                r_extra               <= 1'b0;
            end else begin
                r_len  <= w_len_last;
                r_widx <= 4'd0;
                for (int j = 0; j < 16; j++) begin
                    if (5'(j) == {1'b0, r_widx}) begin
                        r_buf[15-j] <= w_last_word;
                    end else if (5'(j) > {1'b0, r_widx}) begin
                        r_buf[15-j] <= (5'(j) == w_p) ? c_PAD_WORD : 64'd0;
                    end
                end
                if (w_p <= 5'd13) begin
                    r_buf[1]  <= w_field_last[127:64];
                    r_buf[0]  <= w_field_last[63:0];
                    r_last    <= 1'b1;
                    r_extra   <= 1'b0;
                end else begin
                    r_last    <= 1'b0;
                    r_extra   <= 1'b1;
                end
                r_p16 <= (w_p == 5'd16);
            end
        end else if (w_hs) begin
            if (r_extra) begin
                // Length-only chunk follows straight on from the current one
                r_buf     <= '0;
                r_buf[15] <= r_p16 ? c_PAD_WORD : 64'd0;
                r_buf[1]  <= w_field_cur[127:64];
                r_buf[0]  <= w_field_cur[63:0];
                r_last    <= 1'b1;
                r_extra   <= 1'b0;
            end else begin
                r_last <= 1'b0;
                if (r_last) begin
                    r_len  <= '0;
                    r_widx <= 4'd0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sha512_padder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sha512_padder
//  Purpose  : Self-checking bench for sha512_padder against a byte-level
//             FIPS 180-4 padding model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sha512_padder;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [63:0]   in_data;
    logic          in_last;
    logic [3:0]    in_bytes;
    logic          chunk_valid;
    logic          chunk_ready;
    logic [1023:0] chunk;
    logic          chunk_last;

    int checks   = 0;
    int failures = 0;

    logic [7:0]    g_msg[$];
    logic [1023:0] g_rx[$];

    sha512_padder #(.LEN_W(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_bytes   (in_bytes),
        .chunk_valid(chunk_valid),
        .chunk_ready(chunk_ready),
        .chunk      (chunk),
        .chunk_last (chunk_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sends g_msg as a word stream and checks every produced chunk against
    // the padded-message model; received chunks are left in g_rx.
    task automatic run_msg(input bit tail_empty, input int stall_pct, input bit hold5);
        logic [7:0]    pad[$];
        logic [1023:0] exp_q[$];
        bit            exp_l[$];
        logic [63:0]   wd[$];
        bit            wl[$];
        logic [3:0]    wb[$];
        logic [1023:0] v;
        logic [1023:0] hold_ref;
        logic          hold_last;
        logic [63:0]   w;
        longint unsigned bits;
        int L, nfull, rem, nch, cyc, wic, hold_cnt;
        bit exp_v, exp_r;

        L    = g_msg.size();
        bits = 64'(L) * 64'd8;
        pad  = g_msg;
        pad.push_back(8'h80);
        while (pad.size() % 128 != 112) pad.push_back(8'h00);
        for (int i = 0; i < 8; i++) pad.push_back(8'h00);
        for (int i = 7; i >= 0; i--) pad.push_back(8'(bits >> (8*i)));
        nch = pad.size() / 128;
        for (int c = 0; c < nch; c++) begin
            for (int b = 0; b < 128; b++) v[1023-8*b -: 8] = pad[c*128+b];
            exp_q.push_back(v);
            exp_l.push_back(c == nch-1);
        end

        nfull = L / 8;
        rem   = L % 8;
        for (int i = 0; i < nfull; i++) begin
            for (int k = 0; k < 8; k++) w[63-8*k -: 8] = g_msg[i*8+k];
            wd.push_back(w);
            if (rem == 0 && !tail_empty && i == nfull-1) begin
                wl.push_back(1'b1);
                wb.push_back(4'($urandom_range(8, 15)));
            end else begin
                wl.push_back(1'b0);
                wb.push_back(4'($urandom_range(0, 15)));
            end
        end
        if (rem != 0 || tail_empty || L == 0) begin
            w = {$urandom, $urandom};
            for (int k = 0; k < rem; k++) w[63-8*k -: 8] = g_msg[nfull*8+k];
            wd.push_back(w);
            wl.push_back(1'b1);
            wb.push_back(4'(rem));
        end

        g_rx.delete();
        cyc = 0; wic = 0; hold_cnt = 0; exp_v = 0; exp_r = 0;
        while ((wd.size() > 0 || exp_q.size() > 0) && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            in_valid    = 1'b0;
            chunk_ready = 1'b0;
            in_last     = 1'($urandom_range(0, 1));
            in_data     = {$urandom, $urandom};
            in_bytes    = 4'($urandom_range(0, 15));
            if (exp_v) begin chk("chunk_valid_timing", chunk_valid, 1'b1); exp_v = 0; end
            if (exp_r) begin chk("in_ready_after_final", in_ready, 1'b1); exp_r = 0; end
            if (chunk_valid) begin
                if (hold5 && hold_cnt < 5) begin
                    if (hold_cnt == 0) begin
                        hold_ref  = chunk;
                        hold_last = chunk_last;
                    end else begin
                        chk("hold_chunk_stable", chunk, hold_ref);
                        chk("hold_last_stable", chunk_last, hold_last);
                    end
                    chk("hold_in_ready_low", in_ready, 1'b0);
                    hold_cnt++;
                end else if ($urandom_range(0, 99) >= stall_pct) begin
                    chunk_ready = 1'b1;
                    if (exp_q.size() == 0) begin
                        chk("spurious_chunk", 32'(exp_q.size()), 32'd1);
                    end else begin
                        chk("chunk_data", chunk, exp_q[0]);
                        chk("chunk_last", chunk_last, exp_l[0]);
                        g_rx.push_back(chunk);
                        void'(exp_q.pop_front());
                        void'(exp_l.pop_front());
                        if (exp_q.size() > 0 && wd.size() == 0) exp_v = 1;
                        if (exp_q.size() == 0) exp_r = 1;
                    end
                end
            end else if (wd.size() > 0 && in_ready && $urandom_range(0, 99) >= stall_pct) begin
                in_valid = 1'b1;
                in_data  = wd.pop_front();
                in_last  = wl.pop_front();
                in_bytes = wb.pop_front();
                wic++;
                if (in_last || wic == 16) begin
                    exp_v = 1;
                    wic   = 0;
                end
            end
        end
        chk("message_timeout", 1'(cyc < 4000), 1'b1);
        @(negedge clk);
        in_valid    = 1'b0;
        chunk_ready = 1'b0;
        if (exp_r) chk("in_ready_after_final", in_ready, 1'b1);
        chk("idle_no_chunk", chunk_valid, 1'b0);
    endtask

    task automatic rand_msg(input int L);
        g_msg.delete();
        for (int i = 0; i < L; i++) g_msg.push_back(8'($urandom_range(0, 255)));
    endtask

    initial begin
        reset       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        in_last     = 1'b0;
        in_bytes    = '0;
        chunk_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_chunk_valid", chunk_valid, 1'b0);
        chk("rst_chunk_last", chunk_last, 1'b0);
        chk("rst_chunk", chunk, '0);
        reset = 1'b1;
        @(negedge clk);

        // Empty message
        g_msg.delete();
        run_msg(1'b1, 0, 1'b0);
        chk("empty_nchunks", 32'(g_rx.size()), 32'd1);
        if (g_rx.size() > 0) begin
            chk("empty_word0", g_rx[0][1023 -: 64], 64'h8000_0000_0000_0000);
            chk("empty_rest", g_rx[0][959:0], '0);
        end

        // "abc"
        g_msg = '{8'h61, 8'h62, 8'h63};
        run_msg(1'b0, 0, 1'b0);
        if (g_rx.size() > 0) begin
            chk("abc_word0", g_rx[0][1023 -: 64], 64'h6162_6380_0000_0000);
            chk("abc_word15", g_rx[0][63:0], 64'h18);
        end

        // 112 bytes, last word full: pad lands in word 14, length in an extra chunk
        rand_msg(112);
        run_msg(1'b0, 0, 1'b0);
        chk("m112_nchunks", 32'(g_rx.size()), 32'd2);
        if (g_rx.size() == 2) begin
            chk("m112_a_word14", g_rx[0][127:64], 64'h8000_0000_0000_0000);
            chk("m112_a_word15", g_rx[0][63:0], 64'h0);
            chk("m112_b_word15", g_rx[1][63:0], 64'h380);
            chk("m112_b_rest", g_rx[1][1023:64], '0);
        end

        // 128 bytes, last word full at the end of a chunk
        rand_msg(128);
        run_msg(1'b0, 0, 1'b0);
        chk("m128_nchunks", 32'(g_rx.size()), 32'd2);
        if (g_rx.size() == 2) begin
            chk("m128_b_word0", g_rx[1][1023 -: 64], 64'h8000_0000_0000_0000);
            chk("m128_b_word15", g_rx[1][63:0], 64'h400);
        end

        // Downstream stall, then a second independent message
        rand_msg(20);
        run_msg(1'b0, 0, 1'b1);
        rand_msg(40);
        run_msg(1'b1, 0, 1'b0);

        // Reset after 7 words of a message
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_last  = 1'b0;
            in_data  = {$urandom, $urandom};
            @(negedge clk);
        end
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("midmsg_rst_in_ready", in_ready, 1'b1);
        chk("midmsg_rst_valid", chunk_valid, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        // Reset while a chunk is being presented
        in_valid = 1'b1;
        in_last  = 1'b1;
        in_bytes = 4'd5;
        in_data  = {$urandom, $urandom};
        @(negedge clk);
        in_valid = 1'b0;
        chk("emit_before_rst", chunk_valid, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk("emit_rst_valid", chunk_valid, 1'b0);
        chk("emit_rst_last", chunk_last, 1'b0);
        chk("emit_rst_chunk", chunk, '0);
        chk("emit_rst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        reset = 1'b1;

        g_msg = '{8'h61, 8'h62, 8'h63};
        run_msg(1'b0, 0, 1'b0);
        if (g_rx.size() > 0) chk("post_rst_abc_len", g_rx[0][63:0], 64'h18);

        // Randomized lengths, gaps and stalls
        for (int m = 0; m < 10; m++) begin
            rand_msg($urandom_range(0, 300));
            run_msg(1'($urandom_range(0, 1)), $urandom_range(0, 40), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
